mul_arb: RTL and testbench

MUL_ARB -- requirements
Module: mul_arb

---
 rtl/mul_arb_pkg.sv | 23 ++
 rtl/mul_arb_rr.sv | 48 ++++
 rtl/mul_arb.sv | 131 +++++++++++++
 tb/tb_mul_arb.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and op encodings for the two-requester multiplier front end.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam logic [3:0] OpMul    = 4'b0001;
  localparam logic [3:0] OpMulh   = 4'b0010;
  localparam logic [3:0] OpMulhsu = 4'b0100;
  localparam logic [3:0] OpMulhu  = 4'b1000;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OpMul, OpMulh, OpMulhsu, OpMulhu: op_legal = 1'b1;
      default:                          op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_arb_rr.sv
// Two-way grant logic with last-granted pointer.
// MUL_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module mul_arb_rr (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic en,
  input  logic accept,
  output logic grant0,
  output logic grant1
);

`ifdef MUL_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  // last_q holds the index of the last granted requester; reset to 1 so 0 wins first.
  logic last_q;
  logic prio1;

  assign prio1 = RrEn & ~last_q;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (en) begin
      if (valid0 && valid1) begin
        grant1 = prio1;
        grant0 = ~prio1;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant1;
    end
  end

endmodule

// File: rtl/mul_arb.sv
// Arbitrates two requesters onto one external multiplier, one op in flight.
// Define MUL_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
module mul_arb
  import mul_arb_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [3:0]       req0_op_i,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [3:0]       req1_op_i,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_src_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [31:0]      rsp_data_o,
  output logic [31:0]      mul_multiplicand_o,
  output logic [31:0]      mul_multiplier_o,
  output logic [3:0]       mul_op_o,
  output logic             mul_start_o,
  output logic             mul_ctrl_ready_o,
  input  logic [31:0]      mul_result_i,
  input  logic             mul_busy_i,
  input  logic             mul_valid_i,
  input  logic             flush_i
);

  state_e           state_q, state_d;
  logic             drop_q, drop_d;
  logic             en_q;
  logic [3:0]       op_q;
  logic [31:0]      a_q, b_q, data_q;
  logic [TAG_W-1:0] tag_q;
  logic             src_q;

  logic             grant0, grant1, arb_en, hs, capture;
  logic [3:0]       sel_op;

  // No grant while the multiplier is still busy (e.g. an op orphaned by reset).
  assign arb_en  = (state_q == StIdle) && en_q && !flush_i && !mul_busy_i;
  assign hs      = grant0 | grant1;
  assign sel_op  = grant1 ? req1_op_i : req0_op_i;
  assign capture = (state_q == StWait) && mul_valid_i && !mul_busy_i;

  mul_arb_rr u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid0 (req0_valid_i),
    .valid1 (req1_valid_i),
    .en     (arb_en),
    .accept (hs),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready_o       = grant0;
  assign req1_ready_o       = grant1;
  assign rsp_valid_o        = (state_q == StResp);
  assign rsp_src_o          = src_q;
  assign rsp_tag_o          = tag_q;
  assign rsp_data_o         = data_q;
  assign mul_multiplicand_o = a_q;
  assign mul_multiplier_o   = b_q;
  assign mul_op_o           = op_q;
  assign mul_ctrl_ready_o   = en_q;

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    mul_start_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (hs) state_d = op_legal(sel_op) ? StIssue : StResp;
      end
      StIssue: begin
        mul_start_o = 1'b1;
        state_d     = StWait;
        if (flush_i) drop_d = 1'b1;
      end
      StWait: begin
        mul_start_o = mul_busy_i;
        if (flush_i) drop_d = 1'b1;
        if (capture) state_d = (drop_q || flush_i) ? StIdle : StResp;
      end
      StResp: begin
        if (flush_i || rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      drop_q  <= 1'b0;
      en_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      src_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      en_q    <= 1'b1;
      if (hs) begin
        op_q   <= sel_op;
        a_q    <= grant1 ? req1_a_i : req0_a_i;
        b_q    <= grant1 ? req1_b_i : req0_b_i;
        tag_q  <= grant1 ? req1_tag_i : req0_tag_i;
        src_q  <= grant1;
        data_q <= '0;
      end else if (capture) begin
        data_q <= mul_result_i;
      end
    end
  end

endmodule

// File: tb/tb_mul_arb.sv
// Directed bench for mul_arb with a simple 5-cycle multiplier stand-in.
module tb_mul_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_tag = '0, req1_tag = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_src;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_data, mul_a, mul_b;
  logic [3:0]  mul_op;
  logic        mul_start, mul_ctrl_ready;
  logic        flush = 1'b0;

  logic        m_busy = 1'b0, m_valid = 1'b0;
  logic [31:0] m_res = '0;
  int          m_cnt = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mul_arb #(.TAG_W(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req0_valid_i       (req0_valid),
    .req0_ready_o       (req0_ready),
    .req0_op_i          (req0_op),
    .req0_a_i           (req0_a),
    .req0_b_i           (req0_b),
    .req0_tag_i         (req0_tag),
    .req1_valid_i       (req1_valid),
    .req1_ready_o       (req1_ready),
    .req1_op_i          (req1_op),
    .req1_a_i           (req1_a),
    .req1_b_i           (req1_b),
    .req1_tag_i         (req1_tag),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_src_o          (rsp_src),
    .rsp_tag_o          (rsp_tag),
    .rsp_data_o         (rsp_data),
    .mul_multiplicand_o (mul_a),
    .mul_multiplier_o   (mul_b),
    .mul_op_o           (mul_op),
    .mul_start_o        (mul_start),
    .mul_ctrl_ready_o   (mul_ctrl_ready),
    .mul_result_i       (m_res),
    .mul_busy_i         (m_busy),
    .mul_valid_i        (m_valid),
    .flush_i            (flush)
  );

  function automatic logic [31:0] mul_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'b0, a};
    eb = {32'b0, b};
    if (op == 4'b0010 || op == 4'b0100) ea = {{32{a[31]}}, a};
    if (op == 4'b0010) eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (op == 4'b0001) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier stand-in: busy 5 cycles after start, then a 1-cycle valid pulse. Not reset.
  always @(posedge clk) begin
    if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else begin
      m_valid <= 1'b0;
      if (mul_start) begin
        m_busy <= 1'b1;
        m_cnt  <= 4;
        m_res  <= mul_model(mul_op, mul_a, mul_b);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input bit s, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    int n;
    @(posedge clk);
    #1;
    if (s) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
    end
    n = 0;
    @(negedge clk);
    while (!(s ? req1_ready : req0_ready) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      @(negedge clk);
    end
    chk("grant_timeout", 32'(n < 40), 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // mode 0: plain release; 1: hold rsp_ready low 5 cycles; 2: flush with rsp_ready.
  task automatic expect_rsp(input int lat, input logic [31:0] data, input bit src,
                            input logic [3:0] tag, input int mode);
    int n;
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 40) begin
      if (m_valid) chk("start_at_busy_fall", 32'(mul_start), 32'd0);
      @(posedge clk);
      #1;
      n++;
      @(negedge clk);
    end
    chk("latency", n, lat);
    chk("rsp_data", rsp_data, data);
    chk("rsp_src", 32'(rsp_src), 32'(src));
    chk("rsp_tag", 32'(rsp_tag), 32'(tag));
    if (lat == 1) chk("illegal_no_start", 32'(mul_start), 32'd0);
    if (mode == 1) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_data", rsp_data, data);
        chk("hold_tag", 32'(rsp_tag), 32'(tag));
        chk("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    if (mode == 2) flush = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    bit          src;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_data;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, saw, bad_follow, exp_g, g;
    vecs[0] = '{src: 1'b0, op: 4'b0001, a: 32'd7, b: 32'hFFFFFFFD, tag: 4'd3,
                exp_data: 32'hFFFFFFEB, lat: 8};
    vecs[1] = '{src: 1'b1, op: 4'b1000, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, tag: 4'd9,
                exp_data: 32'hFFFFFFFE, lat: 8};
    vecs[2] = '{src: 1'b1, op: 4'b0010, a: 32'h80000000, b: 32'h80000000, tag: 4'd1,
                exp_data: 32'h40000000, lat: 8};
    vecs[3] = '{src: 1'b0, op: 4'b0100, a: 32'hFFFFFFFF, b: 32'd2, tag: 4'hA,
                exp_data: 32'hFFFFFFFF, lat: 8};
    vecs[4] = '{src: 1'b1, op: 4'b0011, a: 32'd5, b: 32'd6, tag: 4'd5,
                exp_data: 32'd0, lat: 1};
    vecs[5] = '{src: 1'b0, op: 4'b0001, a: 32'h12345678, b: 32'h10, tag: 4'hF,
                exp_data: 32'h23456780, lat: 8};
    vecs[6] = '{src: 1'b0, op: 4'b0000, a: 32'd9, b: 32'd9, tag: 4'd2,
                exp_data: 32'd0, lat: 1};
    vecs[7] = '{src: 1'b1, op: 4'b1000, a: 32'h00010000, b: 32'h00010000, tag: 4'd7,
                exp_data: 32'd1, lat: 8};

    // Reset state, with both requesters pushing.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_start", 32'(mul_start), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_tag_src", 32'({rsp_tag, rsp_src}), 32'd0);
    chk("rst_operands", mul_a | mul_b | 32'(mul_op), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ctrl_ready", 32'(mul_ctrl_ready), 32'd1);

    foreach (vecs[i]) begin
      issue(vecs[i].src, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      expect_rsp(vecs[i].lat, vecs[i].exp_data, vecs[i].src, vecs[i].tag, 0);
    end

    // Response back-pressure.
    issue(1'b0, 4'b0001, 32'd3, 32'd5, 4'd4);
    expect_rsp(8, 32'd15, 1'b0, 4'd4, 1);

    // Flush together with rsp_ready in RESP.
    issue(1'b1, 4'b0001, 32'd6, 32'd7, 4'd8);
    expect_rsp(8, 32'd42, 1'b1, 4'd8, 2);

    // Flush in IDLE suppresses that cycle's grant.
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd10; req0_b = 32'd11; req0_tag = 4'd6;
    flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_ready", 32'(req0_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("idle_post_flush_ready", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    expect_rsp(8, 32'd110, 1'b0, 4'd6, 0);

    // Flush in WAIT: no response; start tracks busy and drops with it.
    issue(1'b0, 4'b0001, 32'd2, 32'd2, 4'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    saw = 0;
    bad_follow = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1;
      if (m_busy && !mul_start) bad_follow = 1;
      if (m_valid) chk("flush_start_drop", 32'(mul_start), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("flush_no_rsp", saw, 0);
    chk("flush_start_follow", bad_follow, 0);
    issue(vecs[0].src, vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].tag);
    expect_rsp(8, vecs[0].exp_data, 1'b0, vecs[0].tag, 0);

    // Reset mid-WAIT: no response, no grant until the multiplier goes idle.
    issue(1'b1, 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_start", 32'(mul_start), 32'd0);
    chk("midrst_operands", mul_a | mul_b, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd4; req0_b = 32'd4; req0_tag = 4'd2;
    @(negedge clk);
    if (m_busy) chk("busy_blocks_grant", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    issue(1'b0, 4'b0001, 32'd4, 32'd4, 4'd2);
    expect_rsp(8, 32'd16, 1'b0, 4'd2, 0);

    // Both requesters valid for 4 back-to-back ops from a fresh pointer.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_op = 4'b0001; req0_a = 32'd2; req0_b = 32'd3; req0_tag = 4'd1;
    req1_op = 4'b0001; req1_a = 32'd4; req1_b = 32'd5; req1_tag = 4'd2;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
`ifdef MUL_ARB_RR_EN
      exp_g = k % 2;
`else
      exp_g = 0;
`endif
      n = 0;
      while (!(req0_ready || req1_ready) && n < 40) begin
        @(posedge clk);
        #1;
        n++;
        @(negedge clk);
      end
      chk("arb_timeout", 32'(n < 40), 32'd1);
      g = int'(req1_ready);
      chk("arb_grant", g, exp_g);
      @(posedge clk);
      #1;
      expect_rsp(8, (exp_g == 1) ? 32'd20 : 32'd6, exp_g[0], (exp_g == 1) ? 4'd2 : 4'd1, 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
